// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction word at a time from
// instruction memory and issues it, advancing sequentially or on a redirect.
module pc_sequencer #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       IMemReq,
  output logic [5:0] IMemAddr,
  input  logic       IMemAck,
  output logic       InstrValid,
  output logic [5:0] PC,
  output logic [5:0] PCNext,
  input  logic       Redirect,
  input  logic [5:0] PCJin,
  input  logic       Stall,
  output logic [7:0] RetireCount
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } state_t;

  state_t     state, state_nx;
  logic [5:0] addr_q, addr_nx;
  logic [5:0] pc_q, pc_nx;
  logic [7:0] retire_q, retire_nx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      addr_q   <= RESET_PC;
      pc_q     <= RESET_PC;
      retire_q <= '0;
    end else begin
      state    <= state_nx;
      addr_q   <= addr_nx;
      pc_q     <= pc_nx;
      retire_q <= retire_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = addr_q;
    pc_nx     = pc_q;
    retire_nx = retire_q;
    unique case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (IMemAck) begin
          pc_nx    = addr_q;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        // Redirect wins over Stall; a stall simply holds everything in place.
        if (Redirect) begin
          addr_nx   = PCJin;
          retire_nx = retire_q + 8'd1;
          state_nx  = FETCH;
        end else if (!Stall) begin
          addr_nx   = pc_q + 6'd1;
          retire_nx = retire_q + 8'd1;
          state_nx  = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign IMemReq     = (state == FETCH);
  assign InstrValid  = (state == ISSUE);
  assign IMemAddr    = addr_q;
  assign PC          = pc_q;
  assign PCNext      = pc_q + 6'd1;
  assign RetireCount = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main flow plus
// hand-written sequences for wrap-around and mid-operation reset.
module tb_pc_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       IMemReq;
  logic [5:0] IMemAddr;
  logic       IMemAck;
  logic       InstrValid;
  logic [5:0] PC;
  logic [5:0] PCNext;
  logic       Redirect;
  logic [5:0] PCJin;
  logic       Stall;
  logic [7:0] RetireCount;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.RESET_PC(6'd0)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IMemAck(IMemAck),
    .InstrValid(InstrValid),
    .PC(PC),
    .PCNext(PCNext),
    .Redirect(Redirect),
    .PCJin(PCJin),
    .Stall(Stall),
    .RetireCount(RetireCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       ack;
    logic       redir;
    logic       stall;
    logic [5:0] jin;
    logic       req;
    logic [5:0] addr;
    logic       valid;
    logic [5:0] pc;
    logic [5:0] pcn;
    logic [7:0] ret;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic ack, input logic redir, input logic stall,
                              input logic [5:0] jin, input logic req, input logic [5:0] addr,
                              input logic valid, input logic [5:0] pc, input logic [5:0] pcn,
                              input logic [7:0] ret);
    vec_t v;
    v.ack = ack; v.redir = redir; v.stall = stall; v.jin = jin;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.pcn = pcn; v.ret = ret;
    return v;
  endfunction

  // Outputs packed as {req, addr, valid, pc, pcnext, retire}.
  function automatic logic [27:0] snap();
    return {IMemReq, IMemAddr, InstrValid, PC, PCNext, RetireCount};
  endfunction

  function automatic logic [27:0] pack_exp(input logic req, input logic [5:0] addr,
                                           input logic valid, input logic [5:0] pc,
                                           input logic [5:0] pcn, input logic [7:0] ret);
    return {req, addr, valid, pc, pcn, ret};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic ack, input logic redir, input logic stall, input logic [5:0] jin);
    IMemAck  = ack;
    Redirect = redir;
    Stall    = stall;
    PCJin    = jin;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //          ack r s jin | req addr v pc pcn ret
    vecs[0]  = mk(1, 0, 0, 0,   1, 0,  0, 0, 1, 0);   // IDLE -> FETCH, ack ignored
    vecs[1]  = mk(1, 0, 0, 0,   0, 0,  1, 0, 1, 0);
    vecs[2]  = mk(1, 0, 0, 0,   1, 1,  0, 0, 1, 1);
    vecs[3]  = mk(1, 0, 0, 0,   0, 1,  1, 1, 2, 1);
    vecs[4]  = mk(1, 0, 0, 0,   1, 2,  0, 1, 2, 2);
    vecs[5]  = mk(1, 0, 0, 0,   0, 2,  1, 2, 3, 2);
    vecs[6]  = mk(1, 0, 0, 0,   1, 3,  0, 2, 3, 3);
    vecs[7]  = mk(1, 0, 0, 0,   0, 3,  1, 3, 4, 3);
    vecs[8]  = mk(1, 0, 0, 0,   1, 4,  0, 3, 4, 4);
    vecs[9]  = mk(1, 0, 0, 0,   0, 4,  1, 4, 5, 4);
    vecs[10] = mk(1, 0, 0, 0,   1, 5,  0, 4, 5, 5);
    vecs[11] = mk(0, 1, 1, 40,  1, 5,  0, 4, 5, 5);   // wait states, redirect/stall ignored
    vecs[12] = mk(0, 1, 1, 40,  1, 5,  0, 4, 5, 5);
    vecs[13] = mk(0, 0, 0, 0,   1, 5,  0, 4, 5, 5);
    vecs[14] = mk(0, 0, 0, 0,   1, 5,  0, 4, 5, 5);
    vecs[15] = mk(1, 0, 0, 0,   0, 5,  1, 5, 6, 5);
    vecs[16] = mk(0, 1, 0, 16,  1, 16, 0, 5, 6, 6);
    vecs[17] = mk(1, 0, 0, 0,   0, 16, 1, 16, 17, 6);
    vecs[18] = mk(0, 1, 0, 25,  1, 25, 0, 16, 17, 7); // branch 16 -> 25
    vecs[19] = mk(1, 0, 0, 0,   0, 25, 1, 25, 26, 7);
    vecs[20] = mk(1, 0, 1, 0,   0, 25, 1, 25, 26, 7); // stall, ack ignored in ISSUE
    vecs[21] = mk(1, 0, 1, 0,   0, 25, 1, 25, 26, 7);
    vecs[22] = mk(1, 0, 1, 0,   0, 25, 1, 25, 26, 7);
    vecs[23] = mk(0, 1, 1, 9,   1, 9,  0, 25, 26, 8); // redirect beats stall
    vecs[24] = mk(1, 0, 0, 0,   0, 9,  1, 9, 10, 8);

    Reset_n  = 1'b0;
    IMemAck  = 1'b0;
    Redirect = 1'b0;
    Stall    = 1'b0;
    PCJin    = '0;
    #12;
    check("reset_state", {4'h0, snap()}, {4'h0, pack_exp(0, 0, 0, 0, 1, 0)});

    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check("idle_after_release", {4'h0, snap()}, {4'h0, pack_exp(0, 0, 0, 0, 1, 0)});

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].ack, vecs[i].redir, vecs[i].stall, vecs[i].jin);
      check($sformatf("vec%0d", i), {4'h0, snap()},
            {4'h0, pack_exp(vecs[i].req, vecs[i].addr, vecs[i].valid,
                            vecs[i].pc, vecs[i].pcn, vecs[i].ret)});
    end

    // PC wrap: jump to 63, issue, then fall through to address 0.
    step(0, 1, 0, 6'd63);
    check("wrap_fetch63", {26'h0, IMemAddr}, 32'd63);
    step(1, 0, 0, 0);
    check("wrap_pc63", {26'h0, PC}, 32'd63);
    check("wrap_pcnext0", {26'h0, PCNext}, 32'd0);
    step(0, 0, 0, 0);
    check("wrap_addr0", {26'h0, IMemAddr}, 32'd0);
    check("wrap_ret10", {24'h0, RetireCount}, 32'd10);

    // Retire counter wrap: 245 more fetch/issue pairs reach 255.
    for (int i = 0; i < 245; i++) begin
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
    end
    check("ret255", {24'h0, RetireCount}, 32'd255);
    check("ret255_addr", {26'h0, IMemAddr}, 32'd53);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("ret_wrap0", {24'h0, RetireCount}, 32'd0);
    check("ret_wrap_addr", {26'h0, IMemAddr}, 32'd54);

    // Mid-operation reset while fetching address 12.
    step(1, 0, 0, 0);
    step(0, 1, 0, 6'd12);
    check("fetch12", {4'h0, snap()}, {4'h0, pack_exp(1, 12, 0, 54, 55, 1)});
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset", {4'h0, snap()}, {4'h0, pack_exp(0, 0, 0, 0, 1, 0)});
    @(negedge Clk);
    Reset_n = 1'b1;
    IMemAck = 1'b1;
    #1;
    check("idle_again", {31'h0, IMemReq}, 32'd0);
    @(posedge Clk);
    #1;
    check("refetch_reset_pc", {4'h0, snap()}, {4'h0, pack_exp(1, 0, 0, 0, 1, 0)});
    step(1, 0, 0, 0);
    check("reissue", {4'h0, snap()}, {4'h0, pack_exp(0, 0, 1, 0, 1, 0)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
